char_buffer_writer: RTL and testbench
=====================================

Name: char_buffer_writer

Overview:
Terminal-style writer that drives the write port of the 80x24 character buffer RAM (waddr/din/wen/graphic_mode).
- Accepts a byte stream over a valid/ready handshake.
- Interprets control codes and maintains the cursor.
- Implements hardware scrolling through a rotating top-row offset that the video reader adds to its read row.
- Sits between the debug UART/host byte source and the character buffer.

Parameters:
COLS, 80, characters per line
ROWS, 24, lines per screen
ADDR_BITS, 11, buffer address width (COLS*ROWS <= 2**ADDR_BITS)
BLANK, 8'h20, fill byte used for clears
TAB_W, 8, tab stop spacing

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_data  in  8  incoming character/control byte
in_valid  in  1  in_data valid
in_ready  out  1  writer can accept a byte this cycle
waddr  out  ADDR_BITS  buffer write address
wdata  out  8  buffer write data
wen  out  1  buffer write enable
graphic_mode  out  1  attribute bit written alongside wdata
scroll_row  out  5  physical row currently shown as logical row 0 (0..ROWS-1)
cursor_col  out  7  logical cursor column (0..COLS-1)
cursor_row  out  5  logical cursor row (0..ROWS-1)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- States: CLR_ALL, IDLE, CLR_LINE.
- in_ready = (state==IDLE), decoded from the state register. A transfer is in_valid && in_ready.
- Reset values (also applied when reset asserts mid-operation, aborting any clear):
  - state=CLR_ALL, clear counter=0
  - cursor 0,0; scroll_row=0; graphic_mode=0; wen=0; waddr=0; wdata=BLANK
- Address map: phys_row = (scroll_row + row) mod ROWS; addr = phys_row*COLS + col, computed as shift-add with no multiplier.
- Write outputs (waddr, wdata, wen, graphic_mode) are registered. A byte accepted in cycle N produces its write in cycle N+1. Non-writing codes give wen=0 in N+1.
- CLR_ALL: writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, with graphic_mode=0 on every write.
  - Entered from reset or FF.
  - After the last write (1920 cycles from entry): IDLE, cursor 0,0, scroll_row=0.
- IDLE byte decode:
  - 0x20..0xFF printable: write the byte at the cursor with the current graphic_mode, then advance col.
    - If col was COLS-1: col=0 and perform newline.
  - 0x0D CR: col=0.
  - 0x0A LF: newline; col is unchanged.
  - 0x08 BS: col=col-1 if col>0, else no-op. No write; no upward wrap.
  - 0x09 TAB: col = min((col/TAB_W+1)*TAB_W, COLS-1). No write.
  - 0x0C FF: enter CLR_ALL.
  - 0x0E SO: graphic_mode=1.
  - 0x0F SI: graphic_mode=0.
  - All other 0x00..0x1F: ignored; the byte is consumed.
- newline:
  - If row<ROWS-1: row+1, stay IDLE.
  - Else: row stays ROWS-1, scroll_row=(scroll_row+1) mod ROWS, enter CLR_LINE.
- CLR_LINE: writes BLANK (graphic_mode attribute 0) to the COLS addresses of the physical row at the new logical row ROWS-1, one per cycle, then returns to IDLE.
  - in_ready is low for exactly COLS cycles.
  - The clear runs after the triggering character's own write: wrap write in N+1, first clear write in N+2.
- graphic_mode output during clears is 0. The stored mode register is preserved and restored for subsequent writes.
- scroll_row wraps ROWS-1 -> 0. All counters use explicit modulo compares; no reliance on power-of-two overflow.
- in_valid while in_ready=0 is held off by the source. The writer never drops or duplicates a byte.

Decomposition:
- Shared package char_term_pkg holds:
  - COLS/ROWS/BLANK/TAB_W constants
  - control code constants (CC_CR, CC_LF, CC_BS, CC_TAB, CC_FF, CC_SO, CC_SI)
  - state enum
- One sub-module: char_addr_map, combinational (scroll_row, row, col) -> addr. The video reader reuses it for its read side.

Test Plan:
1. Reset, then wait: 1920 consecutive wen pulses with addr 0..1919, wdata=0x20, in_ready=0 throughout; in_ready=1 on cycle 1921; cursor 0,0.
2. Send "AB" back-to-back: writes (0,0x41) then (1,0x42), each one cycle after acceptance; cursor_col=2.
3. Send SO, 'a', SI, 'a': two writes at addr 0 and 1, with graphic_mode=1 for the first and 0 for the second.
4. Send 79 'x', then 'y' at row 0: 'y' written at addr 79; cursor (row1,col0). Then BS at col 0: cursor unchanged, no write.
5. Drive 24 LFs from row 0: after the 24th LF, scroll_row=1, in_ready low 80 cycles, clear writes to addr 0..79; next 'z' at col 0 written to addr 0.
6. Assert reset during CLR_LINE: next cycle wen=0, scroll_row=0, state CLR_ALL restarts from addr 0; FF in IDLE gives the same full-clear sequence.

Source files
------------

// File: rtl/char_buffer_writer_pkg.sv
// Shared constants for the terminal character writer and the video reader.
// Holds the screen geometry, the control codes and the writer state encoding.
package char_term_pkg;

  // Screen geometry and buffer sizing
  localparam int COLS      = 80;
  localparam int ROWS      = 24;
  localparam int ADDR_BITS = 11;
  localparam int TAB_W     = 8;
  localparam int CELLS     = COLS * ROWS;

  // Fill byte written by every clear operation
  localparam logic [7:0] BLANK = 8'h20;

  // Lowest byte value that is written to the screen as a glyph
  localparam logic [7:0] PRINT_MIN = 8'h20;

  // Control codes understood by the writer
  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_SO  = 8'h0E;
  localparam logic [7:0] CC_SI  = 8'h0F;

  // Width-matched limits used by the counters and cursor compares
  localparam logic [6:0]           COL_LAST   = 7'(COLS - 1);
  localparam logic [4:0]           ROW_LAST   = 5'(ROWS - 1);
  localparam logic [ADDR_BITS-1:0] CELL_LAST  = ADDR_BITS'(CELLS - 1);
  localparam logic [ADDR_BITS-1:0] LINE_LAST  = ADDR_BITS'(COLS - 1);
  localparam logic [7:0]           TAB_W8     = 8'(TAB_W);
  localparam logic [7:0]           COLS_LAST8 = 8'(COLS - 1);

  // Writer state encoding (kept as plain constants for older tool flows)
  typedef logic [1:0] state_t;
  localparam state_t ST_CLR_ALL  = 2'd0;
  localparam state_t ST_IDLE     = 2'd1;
  localparam state_t ST_CLR_LINE = 2'd2;

  // Advance a row index by one with explicit wrap at ROWS
  function automatic logic [4:0] next_row_wrap(input logic [4:0] r);
    if (r == ROW_LAST) begin
      return 5'd0;
    end
    return r + 5'd1;
  endfunction

  // Column reached by a tab: next multiple of TAB_W, clamped to the last column
  function automatic logic [6:0] tab_stop(input logic [6:0] c);
    logic [7:0] wide;
    logic [7:0] stop;
    wide = {1'b0, c};
    stop = wide - (wide % TAB_W8) + TAB_W8;
    if (stop > COLS_LAST8) begin
      return COL_LAST;
    end
    return stop[6:0];
  endfunction

endpackage

// File: rtl/char_buffer_writer_addr_map.sv
// Logical (row, col) to physical buffer address translation.
// The top row offset rotates for hardware scrolling, so the physical row is
// (scroll_row + row) mod ROWS. The row base is built from shifted copies of the
// physical row, one per set bit of COLS, so no multiplier is inferred.
module char_addr_map
  import char_term_pkg::*;
(
  input  logic [4:0]           scroll_row,
  input  logic [4:0]           row,
  input  logic [6:0]           col,
  output logic [ADDR_BITS-1:0] addr
);

  localparam logic [ADDR_BITS-1:0] COLS_V = ADDR_BITS'(COLS);

  logic [5:0]           row_sum;
  logic [4:0]           phys_row;
  logic [ADDR_BITS-1:0] row_base;

  // Fold the rotated row back into range, then form phys_row*COLS + col
  always_comb begin
    row_sum = {1'b0, scroll_row} + {1'b0, row};
    if (row_sum >= 6'(ROWS)) begin
      phys_row = 5'(row_sum - 6'(ROWS));
    end else begin
      phys_row = row_sum[4:0];
    end
    row_base = '0;
    for (int i = 0; i < ADDR_BITS; i++) begin
      if (COLS_V[i]) begin
        row_base = row_base + (ADDR_BITS'(phys_row) << i);
      end
    end
    addr = row_base + ADDR_BITS'(col);
  end

endmodule

// File: rtl/char_buffer_writer.sv
// Terminal-style writer for the 80x24 character buffer.
// Accepts one byte per handshake, decodes control codes, tracks the cursor and
// scrolls by rotating the top-row offset instead of moving buffer contents.
// All buffer write outputs are registered: a byte accepted in one cycle shows
// up on the write port in the next cycle.
module char_buffer_writer
  import char_term_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] waddr,
  output logic [7:0]           wdata,
  output logic                 wen,
  output logic                 graphic_mode,
  output logic [4:0]           scroll_row,
  output logic [6:0]           cursor_col,
  output logic [4:0]           cursor_row
);

  state_t               state;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic                 gmode;

  logic                 accept;
  logic                 printable;
  logic                 do_newline;
  logic                 nl_wrap;

  logic [4:0]           map_row;
  logic [6:0]           map_col;
  logic [ADDR_BITS-1:0] map_addr;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // Decode which accepted bytes move the cursor to the next line
  always_comb begin
    printable  = (in_data >= PRINT_MIN);
    do_newline = 1'b0;
    if (accept) begin
      if (printable && (cursor_col == COL_LAST)) begin
        do_newline = 1'b1;
      end else if (in_data == CC_LF) begin
        do_newline = 1'b1;
      end
    end
    nl_wrap = (cursor_row == ROW_LAST);
  end

  // Line clears sweep the bottom logical row; otherwise address the cursor
  always_comb begin
    if (state == ST_CLR_LINE) begin
      map_row = ROW_LAST;
      map_col = clr_cnt[6:0];
    end else begin
      map_row = cursor_row;
      map_col = cursor_col;
    end
  end

  char_addr_map u_addr_map (
    .scroll_row (scroll_row),
    .row        (map_row),
    .col        (map_col),
    .addr       (map_addr)
  );

  // Main state machine: clears, byte decode, cursor and scroll bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_CLR_ALL;
      clr_cnt      <= '0;
      cursor_col   <= '0;
      cursor_row   <= '0;
      scroll_row   <= '0;
      gmode        <= 1'b0;
      graphic_mode <= 1'b0;
      wen          <= 1'b0;
      waddr        <= '0;
      wdata        <= BLANK;
    end else begin
      wen <= 1'b0;
      case (state)
        ST_CLR_ALL: begin
          wen          <= 1'b1;
          waddr        <= clr_cnt;
          wdata        <= BLANK;
          graphic_mode <= 1'b0;
          if (clr_cnt == CELL_LAST) begin
            clr_cnt    <= '0;
            state      <= ST_IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            scroll_row <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        ST_CLR_LINE: begin
          wen          <= 1'b1;
          waddr        <= map_addr;
          wdata        <= BLANK;
          graphic_mode <= 1'b0;
          if (clr_cnt == LINE_LAST) begin
            clr_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (accept) begin
            if (printable) begin
              wen          <= 1'b1;
              waddr        <= map_addr;
              wdata        <= in_data;
              graphic_mode <= gmode;
              if (cursor_col == COL_LAST) begin
                cursor_col <= '0;
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end else begin
              case (in_data)
                CC_CR:  cursor_col <= '0;
                CC_BS: begin
                  if (cursor_col != 7'd0) begin
                    cursor_col <= cursor_col - 7'd1;
                  end
                end
                CC_TAB: cursor_col <= tab_stop(cursor_col);
                CC_FF: begin
                  state   <= ST_CLR_ALL;
                  clr_cnt <= '0;
                end
                CC_SO:  gmode <= 1'b1;
                CC_SI:  gmode <= 1'b0;
                default: begin
                end
              endcase
            end

            if (do_newline) begin
              if (!nl_wrap) begin
                cursor_row <= cursor_row + 5'd1;
              end else begin
                scroll_row <= next_row_wrap(scroll_row);
                state      <= ST_CLR_LINE;
                clr_cnt    <= '0;
              end
            end
          end
        end

        default: begin
          state   <= ST_CLR_ALL;
          clr_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_buffer_writer.sv
// Randomised scoreboard bench for char_buffer_writer.
// A screen model written in plain arithmetic predicts every buffer write
// (address, data, attribute, cycle) when a byte is issued; a monitor pops and
// compares whenever the DUT raises wen.
module tb_char_buffer_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 24;
  localparam int CELLS = COLS * ROWS;
  localparam int TAB_W = 8;
  localparam int BLANK = 32;

  typedef struct {
    int addr;
    int data;
    int gm;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] waddr;
  logic [7:0]  wdata;
  logic        wen;
  logic        graphic_mode;
  logic [4:0]  scroll_row;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  exp_t expQ[$];
  exp_t monEntry;

  int mRow = 0;
  int mCol = 0;
  int mScroll = 0;
  int mGm = 0;

  char_buffer_writer dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .waddr        (waddr),
    .wdata        (wdata),
    .wen          (wen),
    .graphic_mode (graphic_mode),
    .scroll_row   (scroll_row),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endfunction

  function automatic int mAddr(input int row, input int col);
    return ((mScroll + row) % ROWS) * COLS + col;
  endfunction

  function automatic void pushWrite(input int addr, input int data, input int gm, input int cyc);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.gm   = gm;
    e.cyc  = cyc;
    expQ.push_back(e);
  endfunction

  function automatic void pushFullClear(input int firstCyc);
    for (int i = 0; i < CELLS; i++) pushWrite(i, BLANK, 0, firstCyc + i);
  endfunction

  function automatic void modelNewline(input int cur);
    if (mRow < ROWS - 1) begin
      mRow++;
    end else begin
      mScroll = (mScroll + 1) % ROWS;
      for (int i = 0; i < COLS; i++)
        pushWrite(mAddr(ROWS - 1, i), BLANK, 0, cur + 2 + i);
    end
  endfunction

  // Screen model: what one accepted byte does to the buffer and cursor
  function automatic void modelAccept(input logic [7:0] b, input int cur);
    int t;
    if (b >= 8'h20) begin
      pushWrite(mAddr(mRow, mCol), int'(b), mGm, cur + 1);
      if (mCol == COLS - 1) begin
        mCol = 0;
        modelNewline(cur);
      end else begin
        mCol++;
      end
    end else begin
      case (b)
        8'h0D: mCol = 0;
        8'h0A: modelNewline(cur);
        8'h08: if (mCol > 0) mCol--;
        8'h09: begin
          t = (mCol / TAB_W + 1) * TAB_W;
          mCol = (t > COLS - 1) ? COLS - 1 : t;
        end
        8'h0C: begin
          pushFullClear(cur + 2);
          mRow = 0;
          mCol = 0;
          mScroll = 0;
        end
        8'h0E: mGm = 1;
        8'h0F: mGm = 0;
        default: ;
      endcase
    end
  endfunction

  // Monitor: every DUT write must match the head of the expected queue
  always @(posedge clk) begin
    #1;
    if (wen) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %0d with nothing expected (cycle %0d)",
                 waddr, wdata, cycle);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("write_addr", int'(waddr), monEntry.addr);
        checkOutput("write_data", int'(wdata), monEntry.data);
        checkOutput("write_gm", int'(graphic_mode), monEntry.gm);
        checkOutput("write_cycle", cycle, monEntry.cyc);
      end
    end
  end

  // Present one byte and hold it until the writer takes it
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 4000) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: in_ready stayed %0d, required 1", in_ready);
      return;
    end
    in_data  = b;
    in_valid = 1'b1;
    modelAccept(b, cycle);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((!in_ready || expQ.size() != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_drained"}, expQ.size(), 0);
    checkOutput({name, "_ready"}, int'(in_ready), 1);
  endtask

  task automatic checkCursor(input string name);
    checkOutput({name, "_col"}, int'(cursor_col), mCol);
    checkOutput({name, "_row"}, int'(cursor_row), mRow);
    checkOutput({name, "_scroll"}, int'(scroll_row), mScroll);
  endtask

  // Reset entry: assert, hold, release; then time the full clear to ready
  task automatic doReset(input int holdCycles);
    int n;
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    expQ.delete();
    repeat (holdCycles) @(negedge clk);
    reset = 1'b0;
    mRow = 0;
    mCol = 0;
    mScroll = 0;
    mGm = 0;
    pushFullClear(cycle + 1);
    n = 0;
    @(posedge clk);
    #1;
    n++;
    while (!in_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reset_ready_latency", n, CELLS);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int r;
    logic [7:0] b;
    logic [7:0] ctl [4];
    ctl[0] = 8'h00; ctl[1] = 8'h07; ctl[2] = 8'h1B; ctl[3] = 8'h1F;

    // 1: reset and full clear
    doReset(3);
    waitIdle("reset");
    checkCursor("reset");

    // 2: back-to-back printable bytes
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    checkOutput("ab_col", int'(cursor_col), 2);
    waitIdle("ab");

    // 3: graphic mode attribute toggling after a form feed
    applyStimulus(8'h0C);
    waitIdle("ff1");
    applyStimulus(8'h0E);
    applyStimulus(8'h61);
    applyStimulus(8'h0F);
    applyStimulus(8'h61);
    waitIdle("gm");
    checkCursor("gm");

    // 4: end-of-line wrap, backspace at column 0, tab stops
    applyStimulus(8'h0C);
    waitIdle("ff2");
    for (int i = 0; i < COLS - 1; i++) applyStimulus(8'h78);
    applyStimulus(8'h79);
    waitIdle("wrap");
    checkOutput("wrap_row", int'(cursor_row), 1);
    checkOutput("wrap_col", int'(cursor_col), 0);
    applyStimulus(8'h08);
    waitIdle("bs0");
    checkCursor("bs0");
    applyStimulus(8'h09);
    checkOutput("tab_col", int'(cursor_col), 8);
    applyStimulus(8'h08);
    checkOutput("bs_col", int'(cursor_col), 7);
    for (int i = 0; i < 68; i++) applyStimulus(8'h2E);
    applyStimulus(8'h09);
    checkOutput("tab_clamp_col", int'(cursor_col), COLS - 1);
    waitIdle("tab");
    checkCursor("tab");

    // 5: scroll on the 24th line feed
    applyStimulus(8'h0C);
    waitIdle("ff3");
    for (int i = 0; i < ROWS - 1; i++) applyStimulus(8'h0A);
    applyStimulus(8'h0A);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("clr_line_busy", n, COLS);
    checkOutput("scroll_after_wrap", int'(scroll_row), 1);
    applyStimulus(8'h7A);
    waitIdle("scroll");
    checkCursor("scroll");

    // 6: reset in the middle of a line clear, then a form feed full clear
    applyStimulus(8'h0A);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    checkOutput("midreset_wen", int'(wen), 0);
    checkOutput("midreset_scroll", int'(scroll_row), 0);
    checkOutput("midreset_ready", int'(in_ready), 0);
    doReset(2);
    waitIdle("midreset");
    checkCursor("midreset");
    applyStimulus(8'h0C);
    waitIdle("ff4");
    checkCursor("ff4");

    // Random byte stream against the model
    for (int i = 0; i < 450; i++) begin
      r = $urandom_range(199, 0);
      if (r < 110)      b = 8'($urandom_range(255, 32));
      else if (r < 140) b = 8'h0A;
      else if (r < 150) b = 8'h0D;
      else if (r < 160) b = 8'h08;
      else if (r < 170) b = 8'h09;
      else if (r < 178) b = 8'h0E;
      else if (r < 186) b = 8'h0F;
      else if (r < 198) b = ctl[$urandom_range(3, 0)];
      else              b = 8'h0C;
      applyStimulus(b);
      if ((i % 50) == 49) begin
        waitIdle("rand");
        checkCursor("rand");
      end
    end
    waitIdle("final");
    checkCursor("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
